// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency busy window, result applied on the last cycle.
// Optional multiply-accumulate (op 7) is enabled by defining MADD_EN.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MD_Op,
  input  logic        MD_Sgn,
  input  logic        Cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [63:0]   res_reg, res_next;
  logic          madd_reg, madd_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;

  logic          long_op, is_div, go;
  logic [63:0]   smul, umul, calc;
  logic [31:0]   a_mag, b_mag, b_safe, sq_mag, sr_mag, uq, ur;
  logic [63:0]   sdiv, udiv;

  always_comb begin
    long_op = 1'b0;
    is_div  = 1'b0;
    case (MD_Op)
      3'd1, 3'd2: long_op = 1'b1;
      3'd3, 3'd4: begin
        long_op = 1'b1;
        is_div  = 1'b1;
      end
`ifdef MADD_EN
      3'd7: long_op = 1'b1;
`endif
      default: ;
    endcase
  end

  assign go   = Start & ~Cancel & (state_reg != RUN) & (MD_Op != 3'd0);
  assign Busy = (state_reg == RUN) | (Start & ~Cancel & long_op);

  // Operands are consumed at the go edge; the 64-bit result is held until completion.
  assign smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign umul = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes so 0x80000000 / -1 falls out naturally (q=0x80000000, r=0).
  assign a_mag  = A[31] ? (~A + 32'd1) : A;
  assign b_mag  = B[31] ? (~B + 32'd1) : B;
  assign b_safe = (B == 32'd0) ? 32'd1 : b_mag;
  assign sq_mag = a_mag / b_safe;
  assign sr_mag = a_mag % b_safe;
  assign uq     = A / ((B == 32'd0) ? 32'd1 : B);
  assign ur     = A % ((B == 32'd0) ? 32'd1 : B);

  always_comb begin
    if (B == 32'd0) begin
      sdiv = {A, 32'hFFFF_FFFF};
      udiv = {A, 32'hFFFF_FFFF};
    end else begin
      sdiv = {(A[31] ? (~sr_mag + 32'd1) : sr_mag),
              ((A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag)};
      udiv = {ur, uq};
    end
  end

  always_comb begin
    calc = 64'd0;
    case (MD_Op)
      3'd1: calc = smul;
      3'd2: calc = umul;
      3'd3: calc = sdiv;
      3'd4: calc = udiv;
`ifdef MADD_EN
      3'd7: calc = MD_Sgn ? smul : umul;
`endif
      default: ;
    endcase
  end

`ifndef MADD_EN
  logic unused_sgn;
  assign unused_sgn = MD_Sgn;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    res_next   = res_reg;
    madd_next  = madd_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (go) begin
          if (MD_Op == 3'd5) begin
            hi_next = A;
          end else if (MD_Op == 3'd6) begin
            lo_next = A;
          end else if (long_op) begin
            state_next = RUN;
            cnt_next   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            res_next   = calc;
`ifdef MADD_EN
            madd_next  = (MD_Op == 3'd7);
`else
            madd_next  = 1'b0;
`endif
          end
        end
      end
      RUN: begin
        if (cnt_reg == CW'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          // Accumulate uses HI/LO as they stand at the completion edge.
          if (madd_reg) {hi_next, lo_next} = {hi_reg, lo_reg} + res_reg;
          else          {hi_next, lo_next} = res_reg;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      res_reg   <= '0;
      madd_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      res_reg   <= res_next;
      madd_reg  <= madd_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign HI = hi_reg;
  assign LO = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops against an arithmetic model.
// Expectations for op 7 follow MADD_EN when the macro is defined.
module tb_muldiv_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
`ifdef MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, Start, MD_Sgn, Cancel;
  logic [2:0]  MD_Op;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi, exp_lo;

  muldiv_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MD_Op(MD_Op), .MD_Sgn(MD_Sgn),
    .Cancel(Cancel), .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
      $error("check %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: architectural effect of one accepted op on {HI,LO}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic sgn,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = {hi, lo};
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = ua * ub;
      3'd3, 3'd4: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = (op == 3'd3) ? sa / sb : ua / ub;
          r = (op == 3'd3) ? sa % sb : ua % ub;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd5: res = {a, lo};
      3'd6: res = {hi, a};
      3'd7: if (MADD_ON) res = {hi, lo} + (sgn ? 64'(sa * sb) : 64'(ua * ub));
      default: ;
    endcase
    return res;
  endfunction

  task automatic do_op(input logic [2:0] op, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic cancel);
    logic [63:0] expv;
    bit lng;
    int n;
    lng = (op inside {3'd1, 3'd2, 3'd3, 3'd4}) || (MADD_ON && op == 3'd7);
    n   = (op inside {3'd3, 3'd4}) ? DIV_CYCLES : MULT_CYCLES;
    expv = cancel ? {exp_hi, exp_lo} : model(op, sgn, a, b, exp_hi, exp_lo);
    @(negedge clk);
    Start = 1'b1; MD_Op = op; MD_Sgn = sgn; A = a; B = b; Cancel = cancel;
    #1;
    check("busy_c0", 64'(Busy), 64'(lng && !cancel));
    @(negedge clk);
    Start = 1'b0; Cancel = 1'b0; MD_Op = 3'($urandom); A = $urandom; B = $urandom;
    if (lng && !cancel) begin
      for (int i = 1; i <= n; i++) begin
        check("busy_run", 64'(Busy), 64'd1);
        check("hilo_hold", {HI, LO}, {exp_hi, exp_lo});
        @(negedge clk);
        A = $urandom; B = $urandom;
      end
    end
    check("busy_done", 64'(Busy), 64'd0);
    check("hilo_done", {HI, LO}, expv);
    {exp_hi, exp_lo} = expv;
    $display("op=%0d sgn=%0d a=%h b=%h cancel=%0d -> HI=%h LO=%h", op, sgn, a, b, cancel, HI, LO);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MD_Op = '0; MD_Sgn = 1'b0; Cancel = 1'b0; A = '0; B = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);

    // mult -3*7
    do_op(3'd1, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    // divu / div
    do_op(3'd4, 1'b0, 32'd100, 32'd7, 1'b0);
    check("divu_const", {HI, LO}, {32'd2, 32'd14});
    do_op(3'd3, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    // divide by zero and overflow
    do_op(3'd3, 1'b0, 32'd5, 32'd0, 1'b0);
    check("div0_const", {HI, LO}, {32'd5, 32'hFFFF_FFFF});
    do_op(3'd3, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("divovf_const", {HI, LO}, {32'd0, 32'h8000_0000});
    // mthi/mtlo back to back
    do_op(3'd5, 1'b0, 32'd1234, 32'd0, 1'b0);
    do_op(3'd6, 1'b0, 32'd5678, 32'd0, 1'b0);
    check("mtx_const", {HI, LO}, {32'd1234, 32'd5678});
    // cancelled op and op 0
    do_op(3'd2, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    do_op(3'd0, 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
    // madd: HI/LO = 0/10, -1*4 signed
    do_op(3'd5, 1'b0, 32'd0, 32'd0, 1'b0);
    do_op(3'd6, 1'b0, 32'd10, 32'd0, 1'b0);
    do_op(3'd7, 1'b1, 32'hFFFF_FFFF, 32'd4, 1'b0);
    check("madd_const", {HI, LO}, MADD_ON ? 64'd6 : 64'd10);
    do_op(3'd7, 1'b0, 32'hFFFF_FFFF, 32'd4, 1'b0);

    // reset in the middle of a multu, at cnt==3
    @(negedge clk);
    Start = 1'b1; MD_Op = 3'd2; A = 32'hFFFF_0000; B = 32'h0001_0003; Cancel = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    repeat (MULT_CYCLES - 3) @(negedge clk);
    check("mid_busy", 64'(Busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_hilo", {HI, LO}, 64'd0);
    $display("reset mid-op -> HI=%h LO=%h", HI, LO);

    // random ops
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      do_op(3'($urandom_range(0, 7)), 1'($urandom), ra, rb, ($urandom_range(0, 5) == 0));
    end

    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
